clock_source_nco: RTL and testbench
===================================

// Module: clock_source_nco
// PURPOSE
//  Parametrised multi-channel NCO clock-enable generator; next generation of the fixed-ratio clock source.
//  Derives NUM_CH phase-accurate clock-enable pulses plus 50%-duty phase bits from one reference clock.
//  Per-channel ratio is runtime-reprogrammable; a lock FSM gates outputs until they are stable.
//  Sits between the board refclk and the LTE sample/symbol-rate datapaths (e.g. 1.4 MHz / 8.4 MHz enables from 100 MHz).
// PARAMETERS
//  NUM_CH       2                   number of output channels (1..16)
//  ACC_W        32                  phase accumulator width, bits
//  INC_DEFAULT  {360777253,60129542} packed NUM_CH*ACC_W reset increments; ch0 = LSBs (ch0 1.4 MHz, ch1 8.4 MHz at 100 MHz)
//  LOCK_CYCLES  64                  refclk cycles of settling before locked asserts (>=1)
// PORTS
//  refclk    in   1               reference clock; all logic on rising edge
//  rst       in   1               asynchronous, active-high reset
//  cfg_valid in   1               reconfiguration request
//  cfg_ready out  1               high when a request can be accepted
//  cfg_ch    in   $clog2(NUM_CH)  target channel (minimum width 1)
//  cfg_inc   in   ACC_W           new phase increment
//  cfg_err   out  1               1-cycle pulse: accepted request had cfg_ch >= NUM_CH
//  ce        out  NUM_CH          per-channel 1-cycle clock-enable pulse
//  phase     out  NUM_CH          per-channel accumulator MSB (~50% duty square wave)
//  locked    out  1               outputs valid and stable
// BEHAVIOUR
//  Reset: acc[n]=0, inc[n]=INC_DEFAULT[n], ce=0, phase=0, locked=0, cfg_ready=0, cfg_err=0, state=WAIT, cnt=LOCK_CYCLES-1.
//  Accumulate every cycle, all states: {carry[n],acc[n]} <= acc[n]+inc[n] (ACC_W+1-bit sum, natural wrap).
//  ce[n] registered: ce[n] <= carry[n] & (state==RUN) & ~accept; asserts the cycle after the wrap.
//  phase[n] = acc[n][ACC_W-1], masked to 0 while locked=0.
//  Output frequency = f_refclk * inc / 2^ACC_W; inc=0 -> channel stopped (no ce, phase 0).
//  inc >= 2^(ACC_W-1) is legal; ce may then be high on consecutive cycles.
//  FSM states: WAIT, RUN, RELOCK.
//   WAIT: cnt decrements each cycle; at cnt==0 -> RUN, locked<=1.
//   RUN: cfg_ready=1; accept = cfg_valid & cfg_ready.
//    accept with cfg_ch <  NUM_CH: inc[cfg_ch]<=cfg_inc, acc[cfg_ch]<=0, locked<=0, cnt<=LOCK_CYCLES-1 -> RELOCK.
//    accept with cfg_ch >= NUM_CH: cfg_err pulses one cycle; no state change, locked stays 1.
//   RELOCK: behaves as WAIT; cfg_ready=0; requests are held off, not dropped.
//  locked and cfg_ready are registered; both go low the cycle after accept.
//  Accept coinciding with a wrap on any channel: that ce is suppressed.
//  Unaffected channels keep accumulating during RELOCK, so their phase is preserved; only their ce/phase outputs are masked.
//  rst asserted mid-operation: immediate return to reset values, including inc (runtime config is lost).
//  LOCK_CYCLES==1: locked rises on the first cycle after reset release.
// STRUCTURE
//  Shared package clock_source_pkg holds:
//   - typedef enum {WAIT,RUN,RELOCK} cs_state_t;
//   - function inc_from_hz(f_ref, f_out, acc_w) for elaborating INC_DEFAULT.
//  Sub-module clock_source_phase_acc, one instance per channel via generate:
//   - holds acc/inc registers, load/clear port, carry-registered ce, masked phase.
//  Top level holds the FSM, lock counter, cfg decode and error pulse.
// TESTING
//  T1 reset/lock: ACC_W=8, LOCK_CYCLES=4, INC_DEFAULT ch0=64; release rst -> locked high on cycle 4; then ce[0] every 4 cycles, phase[0] 2 high / 2 low.
//  T2 rates: default params at 100 MHz for 1 ms -> ch0 1400+-1 pulses, ch1 8400+-1 pulses; no ce while locked=0.
//  T3 reconfig: RUN, cfg_ch=0, cfg_inc=128 (ACC_W=8) ->
//   - locked/cfg_ready low for LOCK_CYCLES;
//   - ch0 then pulses every 2 cycles starting from acc=0;
//   - ch1 pulse spacing is unchanged across the relock once masking ends.
//  T4 bad channel: NUM_CH=2, cfg_ch=3 -> cfg_err pulse, locked stays 1, no inc changes; cfg_valid held during RELOCK -> accepted on first RUN cycle.
//  T5 edges: inc=0 -> no ce; inc=255 (ACC_W=8) -> ce on 255 of every 256 cycles; accept on the wrap cycle -> that ce absent.
//  T6 reset mid-relock: assert rst during RELOCK -> all outputs to reset values, inc restored to default, fresh WAIT sequence.

Source files
------------

// File: rtl/clock_source_pkg.sv
// Shared types and elaboration helpers for the NCO clock-enable generator family.
// Lock-sequencer states and increment/width calculators used at elaboration time.
package clock_source_pkg;

    typedef enum logic [1:0] {
        WAIT,
        RUN,
        RELOCK
    } cs_state_t;

    // Width of a field that must index n items; never narrower than one bit.
    function automatic int min_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Phase increment giving f_out from f_ref with an acc_w-bit accumulator, rounded to nearest.
    function automatic logic [63:0] inc_from_hz(input real f_ref, input real f_out, input int acc_w);
        real scaled;
        scaled = f_out * (2.0 ** acc_w) / f_ref;
        return 64'(longint'(scaled));
    endfunction

endpackage

// File: rtl/clock_source_phase_acc.sv
// One NCO channel: phase accumulator with reloadable increment, registered carry
// clock-enable and lock-masked MSB phase output.
module clock_source_phase_acc #(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic             ce_en,
    input  logic             unmask,
    output logic             ce,
    output logic             phase
);

    logic [ACC_W-1:0] acc_p0;
    logic [ACC_W-1:0] inc_p0;
    logic [ACC_W:0]   sum_p0;

    assign sum_p0 = {1'b0, acc_p0} + {1'b0, inc_p0};

    // Stage p0 -> p1: accumulate every cycle; a reload restarts the phase from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0 <= '0;
            inc_p0 <= INC_RST;
            ce     <= 1'b0;
        end else begin
            ce <= sum_p0[ACC_W] & ce_en;
            if (load) begin
                acc_p0 <= '0;
                inc_p0 <= load_inc;
            end else begin
                acc_p0 <= sum_p0[ACC_W-1:0];
            end
        end
    end

    assign phase = acc_p0[ACC_W-1] & unmask;

endmodule

// File: rtl/clock_source_nco.sv
// Multi-channel NCO clock-enable generator: per-channel accumulators plus a lock
// sequencer that masks outputs after reset and after every ratio change.
module clock_source_nco
    import clock_source_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0] INC_DEFAULT = {32'd360777253, 32'd60129542},
    parameter int                      LOCK_CYCLES = 64
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [min_w(NUM_CH)-1:0]  cfg_ch,
    input  logic [ACC_W-1:0]          cfg_inc,
    output logic                      cfg_err,
    output logic [NUM_CH-1:0]         ce,
    output logic [NUM_CH-1:0]         phase,
    output logic                      locked
);

    localparam int                CH_W     = min_w(NUM_CH);
    localparam int                CNT_W    = min_w(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

    cs_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             ch_ok;
    logic             ce_en;

    assign accept = cfg_valid & cfg_ready;
    assign ch_ok  = int'(cfg_ch) < NUM_CH;
    // Any accept suppresses this cycle's enables so no pulse straddles a ratio change.
    assign ce_en  = (state == RUN) & ~accept;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= WAIT;
            cnt       <= CNT_LOAD;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                WAIT, RELOCK: begin
                    if (cnt == '0) begin
                        state     <= RUN;
                        locked    <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (ch_ok) begin
                            state     <= RELOCK;
                            cnt       <= CNT_LOAD;
                            locked    <= 1'b0;
                            cfg_ready <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= WAIT;
                    cnt       <= CNT_LOAD;
                    locked    <= 1'b0;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        clock_source_phase_acc #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_DEFAULT[n*ACC_W +: ACC_W])
        ) u_acc (
            .clk      (refclk),
            .rst      (rst),
            .load     (accept & ch_ok & (cfg_ch == CH_W'(n))),
            .load_inc (cfg_inc),
            .ce_en    (ce_en),
            .unmask   (locked),
            .ce       (ce[n]),
            .phase    (phase[n])
        );
    end

endmodule

// File: tb/tb_clock_source_nco.sv
// Bench for clock_source_nco: closed-form phase model on a small 8-bit instance plus
// long-run rate counting on a default-parameter instance.
module tb_clock_source_nco;

    localparam int                 NCH   = 3;
    localparam int                 W     = 8;
    localparam int                 LOCK  = 4;
    localparam logic [NCH*W-1:0]   INC_A = {8'd0, 8'd24, 8'd64};
    localparam longint             MOD   = 256;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic           rst, cfg_valid, cfg_ready, cfg_err, locked;
    logic [1:0]     cfg_ch;
    logic [W-1:0]   cfg_inc;
    logic [NCH-1:0] ce, phase;

    logic        rst_b, cfg_valid_b, cfg_ready_b, cfg_err_b, locked_b;
    logic [0:0]  cfg_ch_b;
    logic [31:0] cfg_inc_b;
    logic [1:0]  ce_b, phase_b;

    clock_source_nco #(
        .NUM_CH(NCH), .ACC_W(W), .INC_DEFAULT(INC_A), .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(cfg_err), .ce(ce),
        .phase(phase), .locked(locked)
    );

    clock_source_nco dut_b (
        .refclk(refclk), .rst(rst_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .cfg_ch(cfg_ch_b), .cfg_inc(cfg_inc_b), .cfg_err(cfg_err_b), .ce(ce_b),
        .phase(phase_b), .locked(locked_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Behavioural model: each channel's phase is (cycles since clear * inc) mod 256.
    longint         m_inc [NCH];
    longint         m_n   [NCH];
    int             m_elapsed;
    bit             m_locked;
    bit             m_err;
    logic [NCH-1:0] m_ce, m_phase;
    int             cyc;
    bit             pre, acc_ok, good;

    initial forever begin
        @(posedge refclk);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_inc[i] = longint'(INC_A[i*W +: W]);
                m_n[i]   = 0;
            end
            m_elapsed = 0;
            m_locked  = 1'b0;
            m_err     = 1'b0;
            m_ce      = '0;
            cyc       = 0;
        end else begin
            pre    = m_locked;
            acc_ok = pre && cfg_valid;
            good   = cfg_ch < 2'(NCH);
            for (int i = 0; i < NCH; i++) begin
                m_ce[i] = (((m_n[i] + 1) * m_inc[i]) / MOD != (m_n[i] * m_inc[i]) / MOD)
                          && pre && !acc_ok;
                m_n[i]++;
            end
            m_err = acc_ok && !good;
            if (acc_ok && good) begin
                m_inc[cfg_ch] = longint'(cfg_inc);
                m_n[cfg_ch]   = 0;
                m_elapsed     = 0;
                m_locked      = 1'b0;
            end else if (!pre) begin
                m_elapsed++;
                if (m_elapsed >= LOCK) m_locked = 1'b1;
            end
            cyc++;
        end
        for (int i = 0; i < NCH; i++)
            m_phase[i] = m_locked && (((m_n[i] * m_inc[i]) % MOD) >= MOD / 2);
        #1;
        check("ce", 64'(ce), 64'(m_ce));
        check("phase", 64'(phase), 64'(m_phase));
        check("locked", 64'(locked), 64'(m_locked));
        check("cfg_ready", 64'(cfg_ready), 64'(m_locked));
        check("cfg_err", 64'(cfg_err), 64'(m_err));
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge refclk);
    endtask

    task automatic wait_locked();
        for (int i = 0; i < 100 && !locked; i++) @(negedge refclk);
        check("lock_reached", 64'(locked), 64'd1);
    endtask

    // Holds a request until the model says the handshake completes; called on a falling edge.
    task automatic send_cfg(input logic [1:0] ch, input logic [W-1:0] inc, output int acc_cyc);
        bit will;
        bit done;
        done      = 1'b0;
        acc_cyc   = -1;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        for (int i = 0; i < 200 && !done; i++) begin
            will = m_locked;
            @(negedge refclk);
            if (will) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
        end
        cfg_valid = 1'b0;
        check("cfg_accept", 64'(done), 64'd1);
    endtask

    bit done_b = 1'b0;

    initial begin
        int c0, c1, bad;
        c0  = 0;
        c1  = 0;
        bad = 0;
        for (int i = 0; i < 100 && rst_b !== 1'b0; i++) @(negedge refclk);
        for (int i = 0; i < 200 && !locked_b; i++) begin
            @(negedge refclk);
            if (!locked_b && (ce_b != 2'b00 || phase_b != 2'b00 || cfg_ready_b)) bad++;
        end
        check("b_lock", 64'(locked_b), 64'd1);
        check("b_quiet_while_unlocked", 64'(bad), 64'd0);
        for (int i = 0; i < 10000; i++) begin
            @(negedge refclk);
            c0 += int'(ce_b[0]);
            c1 += int'(ce_b[1]);
            if (cfg_err_b || !locked_b) bad++;
        end
        check_range("b_rate_ch0", c0, 139, 141);
        check_range("b_rate_ch1", c1, 839, 841);
        check("b_stable_run", 64'(bad), 64'd0);
        done_b = 1'b1;
    end

    initial begin
        int e, e2, e3, e4, cnt, r, v;
        rst = 1'b1; rst_b = 1'b1;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        cfg_valid_b = 1'b0; cfg_ch_b = '0; cfg_inc_b = '0;
        repeat (3) @(negedge refclk);
        check("rst_ce", 64'(ce), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        rst = 1'b0; rst_b = 1'b0;

        // Startup lock and default ratios
        wait_cyc(3);  check("t1_unlocked_c3", 64'(locked), 64'd0);
                      check("t1_phase_masked", 64'(phase), 64'd0);
        wait_cyc(4);  check("t1_locked_c4", 64'(locked), 64'd1);
        wait_cyc(6);  check("t1_phase_c6", 64'(phase), 64'b011);
        wait_cyc(8);  check("t1_ce_c8", 64'(ce), 64'b001);
                      check("t1_phase_c8", 64'(phase), 64'b010);
        wait_cyc(11); check("t1_ce_c11", 64'(ce), 64'b010);
        wait_cyc(12); check("t1_ce_c12", 64'(ce), 64'b001);

        // Reconfigure ch0 to half rate
        send_cfg(2'd0, 8'd128, e);
        check("t3_locked_low", 64'(locked), 64'd0);
        check("t3_ready_low", 64'(cfg_ready), 64'd0);
        wait_cyc(e + 3); check("t3_still_relock", 64'(locked), 64'd0);
        wait_cyc(e + 4); check("t3_relocked", 64'(locked), 64'd1);
                         check("t3_ready_back", 64'(cfg_ready), 64'd1);
        wait_cyc(e + 6); check("t3_ce0_e6", 64'(ce[0]), 64'd1);
        wait_cyc(e + 7); check("t3_ce0_e7", 64'(ce[0]), 64'd0);
        wait_cyc(e + 8); check("t3_ce0_e8", 64'(ce[0]), 64'd1);

        // Accept landing on a ch0 wrap
        @(negedge refclk);
        send_cfg(2'd0, 8'd64, e2);
        check("t5_accept_on_wrap_cycle", 64'(e2), 64'(e + 10));
        check("t5_wrap_ce_suppressed", 64'(ce), 64'd0);
        wait_locked();

        // Out-of-range channel, then a request held through a relock
        send_cfg(2'd3, 8'd200, e3);
        check("t4_err_pulse", 64'(cfg_err), 64'd1);
        check("t4_locked_kept", 64'(locked), 64'd1);
        @(negedge refclk);
        check("t4_err_single", 64'(cfg_err), 64'd0);
        send_cfg(2'd1, 8'd100, e3);
        send_cfg(2'd2, 8'd255, e4);
        check("t4_held_accept_cycle", 64'(e4), 64'(e3 + 5));

        // Near-full-scale increment
        wait_cyc(e4 + 4);
        cnt = 0;
        repeat (256) begin
            @(negedge refclk);
            cnt += int'(ce[2]);
        end
        check("t5_inc255_count", 64'(cnt), 64'd255);

        // Randomised reconfiguration traffic
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 20)) @(negedge refclk);
            r = int'($urandom_range(0, 9));
            v = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(0, 255));
            send_cfg(2'($urandom_range(0, 3)), W'(v), e);
        end

        // Reset in the middle of a relock
        wait_locked();
        send_cfg(2'd0, 8'd50, e);
        @(negedge refclk);
        rst = 1'b1;
        #1;
        check("t6_ce", 64'(ce), 64'd0);
        check("t6_phase", 64'(phase), 64'd0);
        check("t6_locked", 64'(locked), 64'd0);
        check("t6_ready", 64'(cfg_ready), 64'd0);
        check("t6_err", 64'(cfg_err), 64'd0);
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        wait_cyc(3); check("t6_relock_c3", 64'(locked), 64'd0);
        wait_cyc(4); check("t6_relock_c4", 64'(locked), 64'd1);
        wait_cyc(8); check("t6_default_inc_ce", 64'(ce), 64'b001);

        for (int i = 0; i < 20000 && !done_b; i++) @(negedge refclk);
        check("b_run_complete", 64'(done_b), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
